mips_multicycle_ctrl: RTL
=========================

# mips_multicycle_ctrl

Multicycle control FSM that sequences the MIPS datapath: one shared ALU and one unified instruction/data memory, reused across cycles. It decodes opcode/funct from the instruction register and drives every datapath enable and mux select. It stalls on a memory-ready handshake, traps illegal instructions and counts retired instructions. It sits beside the datapath inside the `mips` top level, which keeps its `clk`, `pc_out` and `alu_result` ports unchanged.

## Interface
- `CNT_W`, 32, width of retired-instruction counter.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `opcode` in 6: IR[31:26], stable from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_we`, `ir_we`, `reg_we` out 1: PC / IR / register-file write enables.
- `mem_re`, `mem_we` out 1: memory read / write strobes.
- `iord` out 1: memory address source; 0 = PC, 1 = ALUOut.
- `reg_dst` out 1: destination register; 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write-back data; 0 = ALUOut, 1 = MDR.
- `alu_src_a` out 1: ALU operand A; 0 = PC, 1 = A.
- `alu_src_b` out 2: ALU operand B; 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `alu_ctrl` out 4: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
- `pc_src` out 2: next PC; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal` out 1: sticky trap flag.
- `state` out 4: current state, for debug.
- `instr_count` out CNT_W: retired instructions.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC 6, R_WB 7, BRANCH 8, ADDI_EXEC 9, ADDI_WB 10, JUMP 11, TRAP 12.
- FETCH: mem_re=1, iord=0, a=0, b=01, ADD, pc_src=00.
  - On mem_ready=1: pulse pc_we and ir_we, go to DECODE.
  - Otherwise hold FETCH with no writes.
- DECODE: a=0, b=11, ADD (branch target into ALUOut). Dispatch on opcode:
  - 0x00 with funct in {0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt} -> EXEC.
  - 0x23 or 0x2B -> MEM_ADDR.
  - 0x04 -> BRANCH.
  - 0x08 -> ADDI_EXEC.
  - 0x02 -> JUMP.
  - Anything else, including R-type with an unlisted funct -> TRAP.
- MEM_ADDR: a=1, b=10, ADD. Go to MEM_READ for 0x23, MEM_WRITE for 0x2B.
- MEM_READ: mem_re=1, iord=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_we=1, reg_dst=0, mem_to_reg=1.
- MEM_WRITE: mem_we=1, iord=1. Hold until mem_ready, then retire.
- EXEC: a=1, b=00; alu_ctrl from funct.
- R_WB: reg_we=1, reg_dst=1, mem_to_reg=0.
- BRANCH: a=1, b=00, SUB, pc_src=01, pc_we=zero.
- ADDI_EXEC: a=1, b=10, ADD.
- ADDI_WB: reg_we=1, reg_dst=0, mem_to_reg=0.
- JUMP: pc_src=10, pc_we=1.
- Retire: MEM_WB, MEM_WRITE (with mem_ready), R_WB, BRANCH, ADDI_WB and JUMP return to FETCH and increment instr_count. The counter wraps at 2^CNT_W modulo.
- TRAP: absorbing. illegal=1; all enables and strobes stay 0; the counter is frozen. Only reset exits TRAP.
- Undriven selects are 0 in every state. alu_ctrl defaults to ADD.

## Timing
- Reset (rst_n=0): state=FETCH, illegal=0, instr_count=0 immediately (asynchronous).
  - All enables and strobes are forced to 0 combinationally while rst_n=0.
  - Reset during any state, including a held memory access, aborts the instruction with no further writes.
  - The first FETCH strobe appears after rst_n rises.
- Latency with mem_ready tied 1: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3 cycles.
- Each cycle mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. The strobe stays asserted and address selects stay stable throughout.
- mem_ready is ignored in all other states.
- pc_we, ir_we and reg_we are single-cycle pulses per instruction.
- instr_count updates on the clock edge that leaves the retiring state.

## Structure
- Package `mips_ctrl_pkg` holds:
  - state enum;
  - opcode and funct constants;
  - alu_ctrl codes;
  - alu_src_b and pc_src encodings.
- Sub-module `mips_alu_decoder`: combinational funct -> alu_ctrl plus a legal-funct flag. Used by the DECODE dispatch and by EXEC.

## Test plan
- Reset, mem_ready=1, opcode 0x00, funct 0x20 -> states 0,1,6,7,0. EXEC shows alu_ctrl=0010. R_WB shows reg_we=1, reg_dst=1. instr_count=1.
- lw (0x23) with mem_ready=0 for 2 cycles in MEM_READ -> 7 cycles total. mem_re and iord=1 held for 3 cycles. MEM_WB shows mem_to_reg=1.
- beq (0x04): with zero=1 -> pc_we=1, pc_src=01 in BRANCH. With zero=0 -> pc_we=0. Both take 3 cycles and increment the count.
- sw 0x2B, addi 0x08, j 0x02 back-to-back -> latencies 4, 4, 3. Exactly one mem_we pulse. JUMP shows pc_src=10. instr_count=3.
- opcode 0x3F, then R-type funct 0x00 after reset -> TRAP, illegal=1. No enable ever asserts again and the count is frozen. A rst_n pulse clears illegal.
- rst_n dropped mid-MEM_WRITE with mem_ready=0 -> mem_we falls the same cycle, state=0, instr_count=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, decoded
// opcode/funct values, ALU operation codes and datapath mux encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC      = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_ADDI_EXEC = 4'd9,
    ST_ADDI_WB   = 4'd10,
    ST_JUMP      = 4'd11,
    ST_TRAP      = 4'd12
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // ALU operand B select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that complete an instruction unconditionally; MEM_WRITE retires
  // only together with mem_ready and is handled separately.
  function automatic logic is_uncond_retire(input state_e s);
    return (s == ST_MEM_WB) || (s == ST_R_WB) || (s == ST_BRANCH) ||
           (s == ST_ADDI_WB) || (s == ST_JUMP);
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational R-type funct decoder: ALU operation plus a flag telling the
// FSM whether the funct is one we implement (otherwise the instruction traps).
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       funct_legal
);

  // Map funct to ALU operation; unknown functs fall back to ADD and are flagged
  always_comb begin
    alu_ctrl    = ALU_ADD;
    funct_legal = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences a shared-ALU, unified-memory
// datapath, stalls on mem_ready, traps illegal instructions and counts
// retired instructions.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic             reg_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic             iord,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic [1:0]       pc_src,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [3:0] fn_alu_ctrl;
  logic       fn_legal;

  // Ungated enables; they are masked by rst_n before leaving the block
  logic pc_we_raw, ir_we_raw, reg_we_raw, mem_re_raw, mem_we_raw;
  logic retire;

  mips_alu_decoder u_alu_dec (
    .funct       (funct),
    .alu_ctrl    (fn_alu_ctrl),
    .funct_legal (fn_legal)
  );

  // Next-state logic and per-state datapath controls
  always_comb begin
    state_d    = state_q;
    pc_we_raw  = 1'b0;
    ir_we_raw  = 1'b0;
    reg_we_raw = 1'b0;
    mem_re_raw = 1'b0;
    mem_we_raw = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_ctrl   = ALU_ADD;
    pc_src     = PCSRC_ALU;

    case (state_q)
      ST_FETCH: begin
        mem_re_raw = 1'b1;
        alu_src_b  = SRCB_FOUR;
        if (mem_ready) begin
          pc_we_raw = 1'b1;
          ir_we_raw = 1'b1;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Precompute the branch target into ALUOut while dispatching
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_RTYPE:     state_d = fn_legal ? ST_EXEC : ST_TRAP;
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDI_EXEC;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_TRAP;
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      end
      ST_MEM_READ: begin
        mem_re_raw = 1'b1;
        iord       = 1'b1;
        if (mem_ready) state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_we_raw = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        mem_we_raw = 1'b1;
        iord       = 1'b1;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = fn_alu_ctrl;
        state_d   = ST_R_WB;
      end
      ST_R_WB: begin
        reg_we_raw = 1'b1;
        reg_dst    = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_we_raw = zero;
        state_d   = ST_FETCH;
      end
      ST_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = ST_ADDI_WB;
      end
      ST_ADDI_WB: begin
        reg_we_raw = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_JUMP: begin
        pc_src    = PCSRC_JUMP;
        pc_we_raw = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_TRAP: begin
        // Absorbing: nothing is driven and only reset leaves
        state_d = ST_TRAP;
      end
      default: state_d = ST_TRAP;
    endcase
  end

  // Retire bookkeeping and sticky trap flag
  always_comb begin
    retire    = is_uncond_retire(state_q) ||
                ((state_q == ST_MEM_WRITE) && mem_ready);
    count_d   = retire ? count_q + CNT_W'(1) : count_q;
    illegal_d = illegal_q || (state_d == ST_TRAP);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  // Enables are forced low while reset is held so an aborted access stops at once
  always_comb begin
    pc_we  = pc_we_raw  & rst_n;
    ir_we  = ir_we_raw  & rst_n;
    reg_we = reg_we_raw & rst_n;
    mem_re = mem_re_raw & rst_n;
    mem_we = mem_we_raw & rst_n;
  end

  assign illegal     = illegal_q;
  assign state       = state_q;
  assign instr_count = count_q;

endmodule
